// File: rtl/accum_buf_pkg.sv
// accum_buf_pkg: shared lane count, width helper and the drain state type
// used by the accumulation buffer.
package accum_buf_pkg;

    localparam int BATCH = 32;

    // Bits needed to index n items (at least one bit).
    function automatic int bw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [2:0] {
        DR_IDLE  = 3'd0,
        DR_FLUSH = 3'd1,
        DR_RD    = 3'd2,
        DR_VLD   = 3'd3,
        DR_DONE  = 3'd4
    } accum_drain_e;

endpackage

// File: rtl/accum_lane.sv
// accum_lane: one registered lane of the accumulate datapath.
// Selects old value (lane masked off), incoming data (fresh start) or
// old + data. Build macro ACCUM_SAT_EN makes the sum saturate at the
// signed DW-bit limits; without it the sum wraps two's complement.
module accum_lane #(
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_load,
    input  logic          i_en,
    input  logic          i_new,
    input  logic [DW-1:0] i_old,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_res
);

    logic [DW-1:0] w_sum;
    logic [DW-1:0] w_nxt;
    logic [DW-1:0] r_res;

`ifdef ACCUM_SAT_EN
    logic [DW:0] w_wide;

    assign w_wide = {i_old[DW-1], i_old} + {i_data[DW-1], i_data};

    // Clamp to the signed range when the extra sign bit disagrees
    always_comb begin
        if (w_wide[DW] != w_wide[DW-1]) begin
            w_sum = w_wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            w_sum = w_wide[DW-1:0];
        end
    end
`else
    assign w_sum = i_old + i_data;
`endif

    // Masked-off lanes carry the old value so the full word can be forwarded
    assign w_nxt = !i_en ? i_old : (i_new ? i_data : w_sum);

    // Lane result register, loaded only when a request occupies stage 1
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_res <= w_nxt;
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/accum_buf.sv
// accum_buf: read-modify-write accumulation buffer with a drain port.
// Request pipeline: edge T samples the request and reads the RAM, edge T+1
// registers the lane results, edge T+2 writes them. Results of the two
// younger requests are forwarded so same-address requests never stall.
// Optional build macro: ACCUM_SAT_EN (saturating lane sums).
//
// state    | meaning
// ---------+----------------------------------------------------------
// DR_IDLE  | accepting accumulate requests, waiting for drain_start
// DR_FLUSH | waiting for the last accepted request to leave stage 1
// DR_RD    | RAM read issued at the current drain address
// DR_VLD   | word presented on out_*, waiting for out_ready
// DR_DONE  | drain_done pulse, back to idle next cycle
module accum_buf #(
    parameter int ADDR_W = 8,
    parameter int DW     = 16,
    parameter int BATCH  = accum_buf_pkg::BATCH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_W-1:0]     i_acc_addr,
    input  logic [BATCH-1:0]      i_acc_en,
    input  logic                  i_acc_new,
    input  logic [BATCH*DW-1:0]   i_acc_data,
    input  logic                  i_drain_start,
    input  logic [ADDR_W-1:0]     i_drain_cnt,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [ADDR_W-1:0]     o_out_addr,
    output logic [BATCH*DW-1:0]   o_out_data,
    output logic                  o_drain_done,
    output logic                  o_busy,
    output logic                  o_err
);

    import accum_buf_pkg::*;

    localparam int WW    = BATCH * DW;
    localparam int DEPTH = 1 << ADDR_W;

    accum_drain_e        r_state;
    accum_drain_e        w_state_nxt;

    logic                r_s1_valid;
    logic [ADDR_W-1:0]   r_s1_addr;
    logic [BATCH-1:0]    r_s1_en;
    logic                r_s1_new;
    logic [WW-1:0]       r_s1_data;

    logic                r_s2_valid;
    logic [ADDR_W-1:0]   r_s2_addr;
    logic [BATCH-1:0]    r_s2_en;
    logic [WW-1:0]       w_s2_data;

    logic                r_s3_valid;
    logic [ADDR_W-1:0]   r_s3_addr;
    logic [WW-1:0]       r_s3_data;

    logic [WW-1:0]       r_mem [DEPTH];
    logic [WW-1:0]       r_rd_data;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [WW-1:0]       w_old;

    logic [ADDR_W-1:0]   r_drain_addr;
    logic [ADDR_W-1:0]   r_drain_cnt;
    logic                r_err;

    logic                w_acc_req;
    logic                w_acc_ok;
    logic                w_last;

    assign w_acc_req = |i_acc_en;
    assign w_acc_ok  = w_acc_req && (r_state == DR_IDLE);
    assign w_last    = (r_drain_addr == r_drain_cnt);

    // Read port belongs to accumulate traffic in idle and to the drain otherwise
    assign w_rd_addr = (r_state == DR_IDLE) ? i_acc_addr : r_drain_addr;

    // RAM: masked write from stage 2, registered read; contents are never reset
    always_ff @(posedge i_clk) begin
        if (r_s2_valid && !i_rst) begin
            for (int i = 0; i < BATCH; i++) begin
                if (r_s2_en[i]) begin
                    r_mem[r_s2_addr][i*DW +: DW] <= w_s2_data[i*DW +: DW];
                end
            end
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Old-value forwarding: the word now being registered (stage 2) wins over
    // the word written on the edge the RAM was read (stage 3), which the read missed
    always_comb begin
        w_old = r_rd_data;
        if (r_s3_valid && (r_s3_addr == r_s1_addr)) begin
            w_old = r_s3_data;
        end
        if (r_s2_valid && (r_s2_addr == r_s1_addr)) begin
            w_old = w_s2_data;
        end
    end

    genvar g;
    generate
        for (g = 0; g < BATCH; g++) begin : g_lane
            accum_lane #(.DW(DW)) u_lane (
                .i_clk  (i_clk),
                .i_load (r_s1_valid),
                .i_en   (r_s1_en[g]),
                .i_new  (r_s1_new),
                .i_old  (w_old[g*DW +: DW]),
                .i_data (r_s1_data[g*DW +: DW]),
                .o_res  (w_s2_data[g*DW +: DW])
            );
        end
    endgenerate

    // Pipeline valid bits; reset discards anything in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_acc_ok;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
        end
    end

    // Pipeline payload, qualified by the valid bits above
    always_ff @(posedge i_clk) begin
        if (w_acc_ok) begin
            r_s1_addr <= i_acc_addr;
            r_s1_en   <= i_acc_en;
            r_s1_new  <= i_acc_new;
            r_s1_data <= i_acc_data;
        end
        r_s2_addr <= r_s1_addr;
        r_s2_en   <= r_s1_en;
        r_s3_addr <= r_s2_addr;
        r_s3_data <= w_s2_data;
    end

    // Drain address/limit bookkeeping and the sticky dropped-request flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drain_addr <= '0;
            r_drain_cnt  <= '0;
            r_err        <= 1'b0;
        end else begin
            if ((r_state == DR_IDLE) && i_drain_start) begin
                r_drain_addr <= '0;
                r_drain_cnt  <= i_drain_cnt;
            end else if ((r_state == DR_VLD) && i_out_ready && !w_last) begin
                r_drain_addr <= r_drain_addr + 1'b1;
            end
            if (w_acc_req && (r_state != DR_IDLE)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Drain FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= DR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM next state; FLUSH may leave once stage 1 is empty because the
    // stage 2 write lands on the same edge, before the RD read
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DR_IDLE:  if (i_drain_start) w_state_nxt = DR_FLUSH;
            DR_FLUSH: if (!r_s1_valid)   w_state_nxt = DR_RD;
            DR_RD:    w_state_nxt = DR_VLD;
            DR_VLD:   if (i_out_ready)   w_state_nxt = w_last ? DR_DONE : DR_RD;
            DR_DONE:  w_state_nxt = DR_IDLE;
            default:  w_state_nxt = DR_IDLE;
        endcase
    end

    // Drain FSM outputs; out_data re-reads the same address while stalled, so it holds
    always_comb begin
        o_out_valid  = (r_state == DR_VLD);
        o_drain_done = (r_state == DR_DONE);
        o_out_data   = (r_state == DR_VLD) ? r_rd_data : '0;
        o_busy       = (r_state != DR_IDLE) || r_s1_valid || r_s2_valid;
    end

    assign o_out_addr = r_drain_addr;
    assign o_err      = r_err;

endmodule

// File: doc/accum_buf.md
# accum_buf

Accumulation buffer that responds to the per-PE accumulate request stream (`acc_addr`/`acc_en`/`acc_new`) emitted by the convolution address generator. Each request merges `BATCH` MAC lane results into a `BATCH`-wide word by read-modify-write, with a per-lane write mask. A drain port with valid/ready handshake streams finished words out to the writeback path.

## Interface
- `ADDR_W`, 8, word address width; depth is 2^ADDR_W words
- `DW`, 16, signed accumulator width per lane
- `BATCH`, `GLOBAL_PARAM::BATCH` (32), lanes per word

- `clk` in 1, clock
- `rst` in 1, synchronous active-high reset (one clock, sync reset: fixed)
- `acc_addr` in ADDR_W, accumulate word address
- `acc_en` in BATCH, per-lane write mask; request present iff nonzero
- `acc_new` in 1, 1: enabled lanes take `acc_data` instead of old value + `acc_data`
- `acc_data` in BATCH*DW, lane i at bits [i*DW +: DW], signed
- `drain_start` in 1, one-cycle pulse, begin drain at word 0
- `drain_cnt` in ADDR_W, last word index to drain (inclusive), sampled on `drain_start`
- `out_valid` out 1, drain word valid
- `out_ready` in 1, consumer accepts
- `out_addr` out ADDR_W, address of presented word
- `out_data` out BATCH*DW, presented word
- `drain_done` out 1, one-cycle pulse after last word is accepted
- `busy` out 1, high while any request is in flight or a drain is active
- `err` out 1, sticky; set by an accumulate request dropped during drain; cleared by `rst` only

## Operation
- Accumulate: a request sampled at edge T commits to memory at edge T+2. For lanes with `acc_en[i]=1`, new = `acc_new` ? `acc_data[i]` : old[i] + `acc_data[i]`. Lanes with `acc_en[i]=0` are unchanged, even when `acc_new=1`.
- Hazard: a request at T+1 or T+2 to the same address sees the lane-merged result of the request at T. This holds for back-to-back same-address requests with disjoint or overlapping masks. Implemented by forwarding; no stalls; one request per cycle sustained.
- Memory contents are not reset. First use of an address requires `acc_new=1`.
- Drain FSM states: IDLE, FLUSH, RD, VLD, DONE.
  - IDLE→FLUSH on `drain_start`. `drain_start` outside IDLE is ignored.
  - FLUSH waits until no accumulate request is in flight (at most 2 cycles), then goes to RD.
  - RD issues a memory read at the current address, then goes to VLD.
  - VLD drives `out_valid=1`. On `out_ready`: if address == `drain_cnt` go to DONE, else increment the address and go to RD.
  - DONE asserts `drain_done` for 1 cycle, then goes to IDLE.
- Any nonzero `acc_en` while the FSM is not in IDLE is dropped and sets `err`.
- `rst` mid-operation returns to IDLE immediately, discards in-flight requests, and clears all outputs.

## Timing
- Reset values: `out_valid`=0, `out_addr`=0, `out_data`=0, `drain_done`=0, `busy`=0, `err`=0.
- Accumulate latency: 2 cycles from request to memory commit. Drain throughput: 1 word per 2 cycles maximum.
- While `out_valid && !out_ready`, `out_addr` and `out_data` are held stable.
- `drain_start` coincident with an accumulate request: the request is accepted (FSM still IDLE), and FLUSH waits for it to commit.
- `drain_cnt` = 2^ADDR_W − 1 drains the whole buffer. The address counter never wraps past `drain_cnt`.

## Configuration
- `ACCUM_SAT_EN` defined: each lane sum saturates to [−2^(DW−1), 2^(DW−1)−1].
- `ACCUM_SAT_EN` undefined: each lane sum wraps modulo 2^DW (two's complement).

## Structure
- `GLOBAL_PARAM` package: `BATCH` and `bw()` (existing); add the drain state enum type `accum_drain_e`.
- Sub-module `accum_lane`: a registered per-lane adder with new/mask select and saturation under the macro, instantiated `BATCH` times.
- Storage is a simple dual-port RAM inferred inline: 1 write port, 1 read port shared by accumulate and drain, arbitrated by FSM state.

## Test plan
- Write lane0=5 to addr 3 (`acc_new`=1, `acc_en`=1), then lane0=7 (`acc_new`=0) one cycle later → drain of addr 3 shows lane0=12.
- Addr 4 preloaded 10 in all lanes, then back-to-back masks 0x1, 0x2, 0x1 with data 1 each cycle → lane0=12, lane1=11, lanes 2..31=10.
- `acc_new`=1 with `acc_en`=0x4 on a word of all 9 → only lane2 is replaced; other lanes stay 9.
- With `ACCUM_SAT_EN` and DW=16: 32760 + 100 → 32767; without the macro → −32676.
- Drain with `drain_cnt`=2 and `out_ready` low for 3 cycles on word 1 → out_addr sequence 0,1,2 with data stable while stalled; `drain_done` pulses once; `busy` falls the cycle after.
- `acc_en`=0xFF in VLD → request dropped, memory unchanged, `err`=1 held until `rst`; `rst` during RD → `out_valid`=0 and FSM in IDLE next cycle.
